ble_tx_sequencer: RTL

Packet-level controller for the FSK modulator. It builds a complete BLE 1M uncoded link-layer packet (preamble, access address, whitened PDU, whitened CRC-24) and streams it one bit per symbol into the modulator's `symVal` input. It paces itself on the modulator's `symDone` pulse and owns the modulator's reset and enable. PDU bytes arrive from the link-layer buffer over a valid/ready byte handshake.

---
 rtl/ble_tx_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ble_tx_sequencer.sv
// BLE 1M uncoded packet sequencer: streams preamble, access address, whitened PDU
// and whitened CRC-24 one bit per modulator symbol, paced by mod_sym_done.
module ble_tx_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic        tx_abort,
    input  logic [31:0] access_addr,
    input  logic [23:0] crc_init,
    input  logic [5:0]  chan_idx,
    input  logic        whiten_en,
    input  logic [7:0]  pdu_len,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        mod_sym_done,
    output logic        mod_rst_n,
    output logic        mod_enable,
    output logic        mod_sym,
    output logic        busy,
    output logic        tx_done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_AA,
        ST_PDU,
        ST_CRC
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] aa_q, aa_d;
    logic [23:0] crc_q, crc_d;
    logic [6:0]  wh_q, wh_d;
    logic        wh_en_q, wh_en_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  fetch_cnt_q, fetch_cnt_d;
    logic [7:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_ready_q, byte_ready_d;
    logic        tx_done_q, tx_done_d;
    logic        underrun_q, underrun_d;

    logic        xfer;
    logic        wh_bit;
    logic        byte_last;
    logic        crc_fb;
    logic [6:0]  wh_step;
    logic [23:0] crc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 8'd0;
            aa_q         <= 32'd0;
            crc_q        <= 24'd0;
            wh_q         <= 7'd0;
            wh_en_q      <= 1'b0;
            len_q        <= 8'd0;
            fetch_cnt_q  <= 8'd0;
            byte_idx_q   <= 8'd0;
            hold_q       <= 8'd0;
            hold_full_q  <= 1'b0;
            shift_q      <= 8'd0;
            byte_ready_q <= 1'b0;
            tx_done_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            aa_q         <= aa_d;
            crc_q        <= crc_d;
            wh_q         <= wh_d;
            wh_en_q      <= wh_en_d;
            len_q        <= len_d;
            fetch_cnt_q  <= fetch_cnt_d;
            byte_idx_q   <= byte_idx_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            tx_done_q    <= tx_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        aa_d         = aa_q;
        crc_d        = crc_q;
        wh_d         = wh_q;
        wh_en_d      = wh_en_q;
        len_d        = len_q;
        fetch_cnt_d  = fetch_cnt_q;
        byte_idx_d   = byte_idx_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        byte_ready_d = 1'b0;
        tx_done_d    = 1'b0;
        underrun_d   = 1'b0;

        xfer      = byte_valid && byte_ready_q;
        wh_step   = {wh_q[5:0], wh_q[6]} ^ (wh_q[6] ? 7'b0010000 : 7'b0000000);
        crc_fb    = crc_q[23] ^ shift_q[0];
        crc_step  = {crc_q[22:0], 1'b0} ^ (crc_fb ? 24'h00065B : 24'h000000);
        byte_last = ({1'b0, byte_idx_q} + 9'd1) == {1'b0, len_q};

        if (xfer) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 8'd1;
        end

        if (tx_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_d     = ST_PRE;
                        bit_cnt_d   = 8'd0;
                        aa_d        = access_addr;
                        crc_d       = crc_init;
                        wh_d        = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3],
                                       chan_idx[4], chan_idx[5], 1'b1};
                        wh_en_d     = whiten_en;
                        len_d       = pdu_len;
                        fetch_cnt_d = 8'd0;
                        byte_idx_d  = 8'd0;
                    end
                end
                ST_PRE: begin
                    if (mod_sym_done) begin
                        if (bit_cnt_q == 8'd7) begin
                            state_d   = ST_AA;
                            bit_cnt_d = 8'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                end
                ST_AA: begin
                    if (mod_sym_done) begin
                        if (bit_cnt_q != 8'd31) begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end else if (len_q == 8'd0) begin
                            state_d   = ST_CRC;
                            bit_cnt_d = 8'd0;
                        end else if (hold_full_q) begin
                            state_d     = ST_PDU;
                            bit_cnt_d   = 8'd0;
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            byte_idx_d  = 8'd0;
                        end else begin
                            state_d    = ST_IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
                ST_PDU: begin
                    if (mod_sym_done) begin
                        crc_d = crc_step;
                        wh_d  = wh_step;
                        if (bit_cnt_q != 8'd7) begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                            shift_d   = {1'b0, shift_q[7:1]};
                        end else if (byte_last) begin
                            state_d   = ST_CRC;
                            bit_cnt_d = 8'd0;
                        end else if (hold_full_q) begin
                            bit_cnt_d   = 8'd0;
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            byte_idx_d  = byte_idx_q + 8'd1;
                        end else begin
                            state_d    = ST_IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
                ST_CRC: begin
                    if (mod_sym_done) begin
                        wh_d  = wh_step;
                        crc_d = {crc_q[22:0], 1'b0};
                        if (bit_cnt_q == 8'd23) begin
                            state_d   = ST_IDLE;
                            tx_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Ready is judged on the current holding state so it re-arms one cycle after a drain.
        if (state_d == ST_IDLE) begin
            hold_full_d = 1'b0;
        end else begin
            byte_ready_d = (state_q != ST_IDLE) && !hold_full_q && !xfer &&
                           (fetch_cnt_q < len_q);
        end
    end

    always_comb begin
        wh_bit = wh_en_q & wh_q[6];
        case (state_q)
            ST_PRE:  mod_sym = aa_q[0] ^ bit_cnt_q[0];
            ST_AA:   mod_sym = aa_q[bit_cnt_q[4:0]];
            ST_PDU:  mod_sym = shift_q[0] ^ wh_bit;
            ST_CRC:  mod_sym = crc_q[23] ^ wh_bit;
            default: mod_sym = 1'b0;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign mod_enable = busy;
    assign mod_rst_n  = busy;
    assign byte_ready = byte_ready_q;
    assign tx_done    = tx_done_q;
    assign underrun   = underrun_q;

endmodule
